// File: rtl/bfu_operand_feeder.sv
// ---------------------------------------------------------------------------
// bfu_operand_feeder
//
// Purpose:
//   Operand sequencer for an 8-point radix-2 decimation-in-time FFT built
//   around an external, purely combinational butterfly unit (BFU). A frame
//   moves through three phases:
//     LOAD    - eight complex samples arrive; each is stored at the
//               bit-reversed position of its arrival index.
//     COMPUTE - twelve butterflies, one per clock (3 stages x 4 butterflies).
//               Operands are read from the buffer and the BFU results are
//               written back in place on the same edge.
//     UNLOAD  - the eight results leave in natural order with a
//               valid/ready handshake.
//   Frames never overlap; the minimum frame time is 8 + 12 + 8 = 28 cycles.
//
// Ports:
//   clk                          rising-edge clock
//   rst                          synchronous active-high reset
//   in_valid / in_ready          input handshake (in_ready only in LOAD)
//   in_real, in_imag             signed 32-bit input sample
//   A_real, A_imag,
//   B_real, B_imag               butterfly operands to the BFU (0 outside COMPUTE)
//   sel_w                        twiddle select W0..W3 (0 outside COMPUTE)
//   X0_real, X0_imag,
//   X1_real, X1_imag             BFU results, combinational from A/B/sel_w
//   out_valid / out_ready        output handshake (out_valid only in UNLOAD)
//   out_real, out_imag           signed 32-bit FFT output sample
//   busy                         high while in COMPUTE
//
// Configuration:
//   FEEDER_SCALE_EN - when defined, every COMPUTE write-back is arithmetically
//                     shifted right by one, giving 1/8 overall scaling across
//                     the three stages. When undefined, results are stored
//                     unmodified. All arithmetic wraps in 32-bit two's
//                     complement.
// ---------------------------------------------------------------------------
module bfu_operand_feeder (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_real,
  input  logic signed [31:0] in_imag,
  output logic signed [31:0] A_real,
  output logic signed [31:0] A_imag,
  output logic signed [31:0] B_real,
  output logic signed [31:0] B_imag,
  output logic        [1:0]  sel_w,
  input  logic signed [31:0] X0_real,
  input  logic signed [31:0] X0_imag,
  input  logic signed [31:0] X1_real,
  input  logic signed [31:0] X1_imag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_real,
  output logic signed [31:0] out_imag,
  output logic               busy
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    UNLOAD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0] in_cnt;
  logic [1:0] stage;
  logic [1:0] bfly;
  logic [2:0] out_cnt;

  logic signed [31:0] mem_re [8];
  logic signed [31:0] mem_im [8];

  logic       in_fire;
  logic       out_fire;
  logic       last_bfly;
  logic [2:0] load_addr;

  logic [2:0] half_w;
  logic [2:0] j_w;
  logic [2:0] g_w;
  logic [2:0] a_idx;
  logic [2:0] b_idx;
  logic [2:0] sel_full;

  logic signed [31:0] wb0_re, wb0_im, wb1_re, wb1_im;

  // Handshake qualifiers. in_valid is ignored outside LOAD and out_ready is
  // ignored outside UNLOAD, so both are gated by the current phase. Arriving
  // sample n lands at the bit-reversed address so the in-place DIT butterflies
  // leave the results in natural order.
  always_comb begin
    in_fire   = (state_q == LOAD) && in_valid;
    out_fire  = (state_q == UNLOAD) && out_ready;
    last_bfly = (stage == 2'd2) && (bfly == 2'd3);
    load_addr = {in_cnt[0], in_cnt[1], in_cnt[2]};
  end

  // Butterfly addressing for stage s and butterfly k:
  //   half = 2^s, j = k mod half, g = k / half,
  //   a = 2*half*g + j, b = a + half, twiddle = j << (2 - s).
  // The twiddle index is kept 3 bits wide and truncated to 2 bits on output.
  always_comb begin
    half_w   = 3'd1 << stage;
    j_w      = {1'b0, bfly} & (half_w - 3'd1);
    g_w      = {1'b0, bfly} >> stage;
    a_idx    = ((g_w << stage) << 1) | j_w;
    b_idx    = a_idx + half_w;
    sel_full = j_w << (2'd2 - stage);
  end

  // Write-back values for the in-place update. With scaling enabled the
  // signed ports make >>> an arithmetic shift, so negative results stay
  // negative.
  always_comb begin
`ifdef FEEDER_SCALE_EN
    wb0_re = X0_real >>> 1;
    wb0_im = X0_imag >>> 1;
    wb1_re = X1_real >>> 1;
    wb1_im = X1_imag >>> 1;
`else
    wb0_re = X0_real;
    wb0_im = X0_imag;
    wb1_re = X1_real;
    wb1_im = X1_imag;
`endif
  end

  // Next-state logic. LOAD ends with the 8th accepted sample, COMPUTE after
  // the last butterfly of stage 2, and UNLOAD with the 8th accepted output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (in_fire && (in_cnt == 3'd7))   state_d = COMPUTE;
      COMPUTE: if (last_bfly)                     state_d = UNLOAD;
      UNLOAD:  if (out_fire && (out_cnt == 3'd7)) state_d = LOAD;
      default:                                    state_d = LOAD;
    endcase
  end

  // State register and frame counters. Reset may arrive in any phase; it
  // drops the partial frame and restarts from an empty LOAD. The 3-bit
  // sample counters wrap to zero on their 8th handshake, so each phase
  // leaves them ready for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      in_cnt  <= 3'd0;
      stage   <= 2'd0;
      bfly    <= 2'd0;
      out_cnt <= 3'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          if (in_fire) in_cnt <= in_cnt + 3'd1;
        end
        COMPUTE: begin
          bfly <= bfly + 2'd1;
          if (last_bfly) begin
            stage <= 2'd0;
          end else if (bfly == 2'd3) begin
            stage <= stage + 2'd1;
          end
        end
        UNLOAD: begin
          if (out_fire) out_cnt <= out_cnt + 3'd1;
        end
        default: begin
          in_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Complex sample buffer. It is deliberately not reset: a new frame always
  // overwrites all eight entries before they are read. During COMPUTE both
  // butterfly outputs are written back on the same edge that advances to the
  // next butterfly; a and b are always distinct, so the two writes never
  // collide.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_re[load_addr] <= in_real;
      mem_im[load_addr] <= in_imag;
    end else if (state_q == COMPUTE) begin
      mem_re[a_idx] <= wb0_re;
      mem_im[a_idx] <= wb0_im;
      mem_re[b_idx] <= wb1_re;
      mem_im[b_idx] <= wb1_im;
    end
  end

  // Output decode. Everything here depends only on registered state and the
  // buffer, so operands to the BFU and output samples are glitch-free within
  // a cycle. Outside their own phase every data output is forced to zero,
  // which also gives the required values while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    A_real    = '0;
    A_imag    = '0;
    B_real    = '0;
    B_imag    = '0;
    sel_w     = 2'd0;
    out_real  = '0;
    out_imag  = '0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
      end
      COMPUTE: begin
        busy   = 1'b1;
        A_real = mem_re[a_idx];
        A_imag = mem_im[a_idx];
        B_real = mem_re[b_idx];
        B_imag = mem_im[b_idx];
        sel_w  = sel_full[1:0];
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_real  = mem_re[out_cnt];
        out_imag  = mem_im[out_cnt];
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule
